// File: rtl/psx_button_events_if.sv
// ----------------------------------------------------------------------------
// psx_button_events_if
//   Valid/ready handshake carrying debounced button events from the
//   psx_button_events FIFO to the game logic.
//
//   evt_valid  producer -> consumer  FIFO not empty, evt_data is meaningful
//   evt_ready  consumer -> producer  consumer takes evt_data this cycle
//   evt_data   producer -> consumer  [4] 1=press/0=release, [3:0] button index
// ----------------------------------------------------------------------------
interface psx_button_events_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_data;

  modport master (output evt_valid, output evt_data, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface

// File: rtl/psx_button_events.sv
// ----------------------------------------------------------------------------
// psx_button_events
//   Synchronises the raw active-low button word from psx_console, debounces
//   each button on a slow sample tick, publishes active-high held levels and
//   queues one press/release event per debounced transition in a small
//   first-word-fall-through FIFO.
//
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   button_state  in   raw button word, 0 = pressed
//   buttons_held  out  debounced levels, 1 = pressed
//   evt           master side of the event handshake (valid/ready/data)
//   drop_cnt      out  saturating count of press/release pairs that cancelled
//                      before they could be queued
// ----------------------------------------------------------------------------
module psx_button_events #(
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                button_state,
  output logic [15:0]                buttons_held,
  psx_button_events_if.master        evt,
  output logic [7:0]                 drop_cnt
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int STB_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam int PTR_W = FIFO_AW + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_SAMPLES - 1);

  // Registers
  logic [15:0]      sync1_q, sync2_q;
  logic [15:0]      held_q, held_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [STB_W-1:0] stb_q [16];
  logic [STB_W-1:0] stb_d [16];
  logic [15:0]      pend_q, pend_d;
  logic [7:0]       drop_q, drop_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]       data_q, data_d;
  logic [4:0]       mem_q [FIFO_DEPTH];

  // Combinational helpers
  logic [15:0] raw_p, flip, scan_clr, pend_scan, collide;
  logic        tick, full, empty, push, pop;
  logic [3:0]  scan_k;
  logic [4:0]  push_data;
  logic [8:0]  drop_sum;

  // Inverted so that the rest of the block works in "1 = pressed".
  assign raw_p = ~sync2_q;
  assign tick  = (div_q == DIV_LAST);

  // Debounce: a bit flips only after STABLE_SAMPLES consecutive ticks that
  // disagree with the held level; any agreeing tick restarts the count.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    held_d = held_q;
    stb_d  = stb_q;
    flip   = '0;
    if (tick) begin
      for (int i = 0; i < 16; i++) begin
        if (raw_p[i] == held_q[i]) begin
          stb_d[i] = '0;
        end else if (stb_q[i] == STB_LAST) begin
          held_d[i] = ~held_q[i];
          stb_d[i]  = '0;
          flip[i]   = 1'b1;
        end else begin
          stb_d[i] = stb_q[i] + 1'b1;
        end
      end
    end
  end

  // Scanner, pending mask and FIFO control.
  always_comb begin
    full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
            (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    empty = (wr_q == rd_q);
    pop   = !empty && evt.evt_ready;

    scan_k = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) scan_k = 4'(i);
    end
    // Fullness is judged before any pop in the same cycle.
    push      = (pend_q != '0) && !full;
    push_data = {held_q[scan_k], scan_k};
    scan_clr  = '0;
    if (push) scan_clr[scan_k] = 1'b1;

    // A flip on a still-pending bit cancels the queued edge; a flip on a bit
    // the scanner just cleared re-arms it for the new edge.
    pend_scan = pend_q & ~scan_clr;
    collide   = flip & pend_scan;
    pend_d    = pend_scan ^ flip;

    drop_sum = {1'b0, drop_q} + 9'($countones(collide));
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    wr_d = wr_q + PTR_W'(push);
    rd_d = rd_q + PTR_W'(pop);

    // evt_data is registered: it shows the next head when the FIFO will be
    // non-empty and otherwise holds the last value shown.
    data_d = data_q;
    if (rd_d != wr_d) begin
      data_d = (rd_d == wr_q) ? push_data : mem_q[rd_d[FIFO_AW-1:0]];
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 16'hFFFF;
      sync2_q <= 16'hFFFF;
      held_q  <= '0;
      div_q   <= '0;
      for (int i = 0; i < 16; i++) stb_q[i] <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= button_state;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      div_q   <= div_d;
      stb_q   <= stb_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries
  // are valid, so clearing the data itself would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign buttons_held  = held_q;
  assign drop_cnt      = drop_q;
  assign evt.evt_valid = !empty;
  assign evt.evt_data  = data_q;

endmodule
